// File: rtl/hps_reset_sequencer.sv
// HPS reset-request sequencer: serves cold/warm/debug requests one at a time.
// Optional STM event vector enabled by defining HPS_RST_SEQ_STM_EN.
module hps_reset_sequencer #(
  parameter int unsigned PULSE_CYCLES   = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned HOLDOFF_CYCLES = 1024
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cold_req,
  input  logic        warm_req,
  input  logic        debug_req,
  input  logic        h2f_reset_n,
  input  logic        clr_err,
  output logic        hps_0_f2h_cold_reset_req_reset_n,
  output logic        hps_0_f2h_warm_reset_req_reset_n,
  output logic        hps_0_f2h_debug_reset_req_reset_n,
  output logic        busy,
  output logic [1:0]  last_type,
  output logic        err_timeout,
  output logic [7:0]  reset_count,
  output logic [27:0] hps_0_f2h_stm_hw_events_stm_hwevents
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_HOLDOFF
  } state_t;

  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] TO_LD    = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLDOFF_CYCLES - 1);

  localparam logic [1:0] T_NONE  = 2'b00;
  localparam logic [1:0] T_DEBUG = 2'b01;
  localparam logic [1:0] T_WARM  = 2'b10;
  localparam logic [1:0] T_COLD  = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, sync2_q;
  logic [2:0]  req_prev_q;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  f2h_n_q, f2h_n_d;
  logic [1:0]  last_type_q, last_type_d;
  logic        err_q, err_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;

  logic [2:0]  req_vec;
  logic [2:0]  req_rise;
  logic [2:0]  pend_clr;
  logic        h2f_s;
  logic        timeout;
  logic        enter_assert;
  logic        fall_seen;
  logic        rise_seen;

  assign req_vec  = {cold_req, warm_req, debug_req};
  assign req_rise = req_vec & ~req_prev_q;
  assign h2f_s    = sync2_q;

  // State register (all flops, synchronous reset)
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      req_prev_q  <= '0;
      pend_q      <= '0;
      f2h_n_q     <= 3'b111;
      last_type_q <= T_NONE;
      err_q       <= 1'b0;
      rst_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= h2f_reset_n;
      sync2_q     <= sync1_q;
      req_prev_q  <= req_vec;
      pend_q      <= pend_d;
      f2h_n_q     <= f2h_n_d;
      last_type_q <= last_type_d;
      err_q       <= err_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f2h_n_d      = f2h_n_q;
    last_type_d  = last_type_q;
    rst_cnt_d    = rst_cnt_q;
    pend_clr     = 3'b000;
    timeout      = 1'b0;
    enter_assert = 1'b0;
    fall_seen    = 1'b0;
    rise_seen    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          enter_assert = 1'b1;
          state_d      = S_ASSERT;
          cnt_d        = PULSE_LD;
          if (pend_q[2]) begin
            last_type_d = T_COLD;
            f2h_n_d     = 3'b011;
            pend_clr    = 3'b111;
          end else if (pend_q[1]) begin
            last_type_d = T_WARM;
            f2h_n_d     = 3'b101;
            pend_clr    = 3'b011;
          end else begin
            last_type_d = T_DEBUG;
            f2h_n_d     = 3'b110;
            pend_clr    = 3'b001;
          end
        end
      end
      S_ASSERT: begin
        if (cnt_q == '0) begin
          f2h_n_d = 3'b111;
          if (last_type_q == T_DEBUG) begin
            state_d = S_HOLDOFF;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = S_WAIT_LOW;
            cnt_d   = TO_LD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAIT_LOW: begin
        if (!h2f_s) begin
          fall_seen = 1'b1;
          state_d   = S_WAIT_HIGH;
          cnt_d     = TO_LD;
        end else if (cnt_q == '0) begin
          timeout = 1'b1;
          state_d = S_HOLDOFF;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAIT_HIGH: begin
        if (h2f_s) begin
          rise_seen = 1'b1;
          state_d   = S_HOLDOFF;
          cnt_d     = HOLD_LD;
          if (rst_cnt_q != 8'hff) rst_cnt_d = rst_cnt_q + 8'd1;
        end else if (cnt_q == '0) begin
          timeout = 1'b1;
          state_d = S_HOLDOFF;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 16'd1;
      end
      default: begin
        state_d = S_IDLE;
        f2h_n_d = 3'b111;
      end
    endcase
  end

  // A new edge in the clearing cycle survives the clear
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | req_rise;
  end

  always_comb begin
    err_d = err_q;
    if (clr_err) err_d = 1'b0;
    if (timeout) err_d = 1'b1;
  end

  // Outputs
  always_comb begin
    busy                              = (state_q != S_IDLE);
    hps_0_f2h_cold_reset_req_reset_n  = f2h_n_q[2];
    hps_0_f2h_warm_reset_req_reset_n  = f2h_n_q[1];
    hps_0_f2h_debug_reset_req_reset_n = f2h_n_q[0];
    last_type                         = last_type_q;
    err_timeout                       = err_q;
    reset_count                       = rst_cnt_q;
  end

`ifdef HPS_RST_SEQ_STM_EN
  logic [5:0] evt_q, evt_d;

  always_comb begin
    evt_d = {last_type_d, timeout, rise_seen, fall_seen, enter_assert};
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) evt_q <= '0;
    else evt_q <= evt_d;
  end

  assign hps_0_f2h_stm_hw_events_stm_hwevents = {22'd0, evt_q};
`else
  logic unused_evt;
  assign unused_evt = ^{enter_assert, fall_seen, rise_seen};
  assign hps_0_f2h_stm_hw_events_stm_hwevents = '0;
`endif

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Directed bench for hps_reset_sequencer (PULSE=4, HOLDOFF=8, TIMEOUT=20).
// Inputs driven and outputs sampled on the falling edge.
module tb_hps_reset_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cold_req, warm_req, debug_req;
  logic        h2f;
  logic        clr_err;
  logic        cold_n, warm_n, debug_n;
  logic        busy;
  logic [1:0]  last_type;
  logic        err;
  logic [7:0]  cnt;
  logic [27:0] stm;

  int tests = 0;
  int fails = 0;
  int multi_low = 0;
  int stm_hi_nz = 0;
  bit ev_en = 1'b0;
  int ev_cnt [4] = '{0, 0, 0, 0};
  int ev_any = 0;

  always #5 clk = ~clk;

  hps_reset_sequencer #(
    .PULSE_CYCLES   (4),
    .TIMEOUT_CYCLES (20),
    .HOLDOFF_CYCLES (8)
  ) dut (
    .clk_clk                              (clk),
    .reset_reset_n                        (rst_n),
    .cold_req                             (cold_req),
    .warm_req                             (warm_req),
    .debug_req                            (debug_req),
    .h2f_reset_n                          (h2f),
    .clr_err                              (clr_err),
    .hps_0_f2h_cold_reset_req_reset_n     (cold_n),
    .hps_0_f2h_warm_reset_req_reset_n     (warm_n),
    .hps_0_f2h_debug_reset_req_reset_n    (debug_n),
    .busy                                 (busy),
    .last_type                            (last_type),
    .err_timeout                          (err),
    .reset_count                          (cnt),
    .hps_0_f2h_stm_hw_events_stm_hwevents (stm)
  );

  always @(negedge clk) begin
    if (!({cold_n, warm_n, debug_n} inside {3'b111, 3'b011, 3'b101, 3'b110}))
      multi_low++;
    if (stm[27:6] != '0) stm_hi_nz++;
    if (ev_en) begin
      for (int i = 0; i < 4; i++) if (stm[i]) ev_cnt[i]++;
      if (stm != '0) ev_any++;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; cold_req = 0; warm_req = 0; debug_req = 0;
    h2f = 1'b1; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({cold_n, warm_n, debug_n, busy, last_type, err, cnt} !== {3'b111, 1'b0, 2'b00, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_state: got %b%b%b b=%b t=%b e=%b c=%0d want 111 b=0 t=00 e=0 c=0",
               cold_n, warm_n, debug_n, busy, last_type, err, cnt);
    end
    tests++;
    if (stm !== 28'd0) begin
      fails++;
      $display("FAIL reset_stm: got %h want 0", stm);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_idle_wait: busy still %b after 200 cycles, want 0", nm, busy);
    end
  endtask

  task automatic test_warm;
    int first = -1;
    int low = 0;
    warm_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) warm_req = 1'b0;
      if (!warm_n) begin
        if (first < 0) first = i;
        low++;
      end
      if (i == 3) begin
        tests++;
        if ({busy, last_type} !== 3'b110) begin
          fails++;
          $display("FAIL warm_assert_state: busy/type %b%b want 1/10", busy, last_type);
        end
      end
    end
    tests++;
    if (first !== 2 || low !== 4) begin
      fails++;
      $display("FAIL warm_pulse: first=%0d low=%0d want first=2 low=4", first, low);
    end
    repeat (5) @(negedge clk);
    h2f = 1'b0;
    repeat (6) @(negedge clk);
    h2f = 1'b1;
    tests++;
    if ({busy, cnt} !== {1'b1, 8'd0}) begin
      fails++;
      $display("FAIL warm_wait_high: busy=%b cnt=%0d want busy=1 cnt=0", busy, cnt);
    end
    wait_idle("warm");
    tests++;
    if ({cnt, last_type, err} !== {8'd1, 2'b10, 1'b0}) begin
      fails++;
      $display("FAIL warm_done: cnt=%0d type=%b err=%b want 1 10 0", cnt, last_type, err);
    end
  endtask

  task automatic test_priority;
    int cl = 0, wl = 0, dl = 0;
    cold_req = 1'b1; debug_req = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin cold_req = 1'b0; debug_req = 1'b0; end
      if (i == 10) h2f = 1'b0;
      if (i == 16) h2f = 1'b1;
      if (!cold_n) cl++;
      if (!warm_n) wl++;
      if (!debug_n) dl++;
    end
    tests++;
    if (cl !== 4 || wl !== 0 || dl !== 0) begin
      fails++;
      $display("FAIL priority_pulses: cold=%0d warm=%0d debug=%0d want 4 0 0", cl, wl, dl);
    end
    tests++;
    if ({busy, last_type, cnt} !== {1'b0, 2'b11, 8'd2}) begin
      fails++;
      $display("FAIL priority_state: busy=%b type=%b cnt=%0d want 0 11 2", busy, last_type, cnt);
    end
  endtask

  task automatic test_debug_during_wait;
    bit seen_idle = 1'b0;
    int early = 0, dl = 0, wl = 0;
    warm_req = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) warm_req = 1'b0;
      if (i == 10) h2f = 1'b0;
      if (i == 14) debug_req = 1'b1;
      if (i == 15) debug_req = 1'b0;
      if (i == 18) h2f = 1'b1;
      if (!busy) seen_idle = 1'b1;
      if (!warm_n) wl++;
      if (!debug_n) begin
        dl++;
        if (!seen_idle) early++;
      end
    end
    tests++;
    if (early !== 0 || dl !== 4 || wl !== 4) begin
      fails++;
      $display("FAIL debug_after_warm: early=%0d debug=%0d warm=%0d want 0 4 4", early, dl, wl);
    end
    tests++;
    if ({busy, last_type, cnt, err} !== {1'b0, 2'b01, 8'd3, 1'b0}) begin
      fails++;
      $display("FAIL debug_state: busy=%b type=%b cnt=%0d err=%b want 0 01 3 0",
               busy, last_type, cnt, err);
    end
  endtask

  task automatic test_edge_wins;
    int dl = 0, wl = 0;
    warm_req = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i == 1) begin warm_req = 1'b0; debug_req = 1'b1; end
      if (i == 2) debug_req = 1'b0;
      if (i == 10) h2f = 1'b0;
      if (i == 16) h2f = 1'b1;
      if (!warm_n) wl++;
      if (!debug_n) dl++;
    end
    tests++;
    if (wl !== 4 || dl !== 4 || cnt !== 8'd4 || busy !== 1'b0) begin
      fails++;
      $display("FAIL edge_wins: warm=%0d debug=%0d cnt=%0d busy=%b want 4 4 4 0", wl, dl, cnt, busy);
    end
  endtask

  task automatic cold_to_release(input string nm);
    bit lo = 1'b0, ok = 1'b0;
    cold_req = 1'b1;
    @(negedge clk);
    cold_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!cold_n) lo = 1'b1;
      if (lo && cold_n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_release: cold_n=%b no 4-cycle pulse seen, want low then high", nm, cold_n);
    end
  endtask

  task automatic test_timeout;
    int k = 0;
    cold_to_release("timeout");
    while (k < 40 && !err) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k !== 20 || err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_latency: k=%0d err=%b want 20 1", k, err);
    end
    wait_idle("timeout");
    tests++;
    if ({err, cnt} !== {1'b1, 8'd4}) begin
      fails++;
      $display("FAIL timeout_sticky: err=%b cnt=%0d want 1 4", err, cnt);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL clr_err: err=%b want 0", err);
    end
  endtask

  task automatic test_clr_collide;
    int k = 0;
    cold_to_release("collide");
    clr_err = 1'b1;
    while (k < 40 && !err) begin
      @(negedge clk);
      k++;
    end
    clr_err = 1'b0;
    tests++;
    if (k !== 20 || err !== 1'b1) begin
      fails++;
      $display("FAIL clr_collide: k=%0d err=%b want 20 1", k, err);
    end
    wait_idle("collide");
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lows = 0;
    bit ok = 1'b0;
    cold_req = 1'b1;
    @(negedge clk);
    cold_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!cold_n) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (!ok || {cold_n, warm_n, debug_n, busy, last_type, err, cnt, stm} !==
        {3'b111, 1'b0, 2'b00, 1'b0, 8'd0, 28'd0}) begin
      fails++;
      $display("FAIL reset_mid: seen=%b f2h=%b%b%b b=%b t=%b e=%b c=%0d stm=%h want 111 0 00 0 0 0",
               ok, cold_n, warm_n, debug_n, busy, last_type, err, cnt, stm);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cold_n || busy) lows++;
    end
    tests++;
    if (lows !== 0) begin
      fails++;
      $display("FAIL reset_no_resume: active cycles=%0d want 0", lows);
    end
  endtask

  task automatic test_saturation;
    int lost = 0;
    ev_en = 1'b1;
    for (int s = 0; s < 300; s++) begin
      bit lo = 1'b0, ok = 1'b0;
      warm_req = 1'b1;
      @(negedge clk);
      warm_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (!warm_n) lo = 1'b1;
        if (lo && warm_n) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) lost++;
      repeat (3) @(negedge clk);
      h2f = 1'b0;
      repeat (4) @(negedge clk);
      h2f = 1'b1;
      for (int i = 0; i < 50 && busy; i++) @(negedge clk);
      @(negedge clk);
    end
    ev_en = 1'b0;
    tests++;
    if (lost !== 0 || cnt !== 8'd255 || err !== 1'b0) begin
      fails++;
      $display("FAIL saturation: lost=%0d cnt=%0d err=%b want 0 255 0", lost, cnt, err);
    end
`ifdef HPS_RST_SEQ_STM_EN
    tests++;
    if (ev_cnt[0] !== 300 || ev_cnt[1] !== 300 || ev_cnt[2] !== 300 || ev_cnt[3] !== 0) begin
      fails++;
      $display("FAIL stm_events: b0=%0d b1=%0d b2=%0d b3=%0d want 300 300 300 0",
               ev_cnt[0], ev_cnt[1], ev_cnt[2], ev_cnt[3]);
    end
`else
    tests++;
    if (ev_any !== 0) begin
      fails++;
      $display("FAIL stm_tied: nonzero cycles=%0d want 0", ev_any);
    end
`endif
  endtask

  task automatic test_invariants;
    tests++;
    if (multi_low !== 0) begin
      fails++;
      $display("FAIL one_low: multi-low cycles=%0d want 0", multi_low);
    end
    tests++;
    if (stm_hi_nz !== 0) begin
      fails++;
      $display("FAIL stm_upper: nonzero cycles=%0d want 0", stm_hi_nz);
    end
  endtask

  initial begin
    test_reset();
    test_warm();
    test_priority();
    test_debug_during_wait();
    test_edge_wins();
    test_timeout();
    test_clr_collide();
    test_reset_mid();
    test_saturation();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
